// File: rtl/nonce_result_scanner_if.sv
// rtl/nonce_result_scanner_if.sv - memory port bundle shared with the nonce-sweep engine
interface nonce_result_scanner_if;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_clk, mem_we, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk, mem_we, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/nonce_result_scanner.sv
// rtl/nonce_result_scanner.sv - scans per-nonce H0 words for target winners and the minimum
// Optional SCAN_WRITEBACK_EN appends a 4-word result record after the last digest.
module nonce_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           result_addr,
  input  logic [31:0]           target,
  output logic                  done,
  nonce_result_scanner_if.master mem,
  output logic                  found,
  output logic [4:0]            win_nonce,
  output logic [4:0]            min_nonce,
  output logic [31:0]           min_h0
);

  localparam logic [4:0]  LAST_N  = 5'(NUM_NONCES - 1);
  localparam logic [15:0] WB_OFFS = 16'(8 * NUM_NONCES);

  typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RWAIT, S_RCAP, S_WB} state_t;

  state_t      state_q, state_d;
  logic [4:0]  n_q, n_d;
  logic [15:0] base_q, base_d;
  logic [31:0] target_q, target_d;
  logic        found_q, found_d;
  logic [4:0]  win_q, win_d;
  logic [4:0]  min_nonce_q, min_nonce_d;
  logic [31:0] min_h0_q, min_h0_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] h0;

  assign h0          = mem.mem_read_data;
  assign done        = (state_q == S_IDLE);
  assign found       = found_q;
  assign win_nonce   = win_q;
  assign min_nonce   = min_nonce_q;
  assign min_h0      = min_h0_q;
  assign mem.mem_clk  = clk;
  assign mem.mem_addr = addr_q;

`ifdef SCAN_WRITEBACK_EN
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  k_next;

  assign k_next             = k_q + 2'd1;
  assign mem.mem_we         = we_q;
  assign mem.mem_write_data = wdata_q;

  function automatic logic [31:0] wb_word(input logic [1:0] k, input logic f,
                                          input logic [4:0] w, input logic [4:0] m,
                                          input logic [31:0] h);
    case (k)
      2'd0:    wb_word = {31'b0, f};
      2'd1:    wb_word = {27'b0, w};
      2'd2:    wb_word = {27'b0, m};
      default: wb_word = h;
    endcase
  endfunction
`else
  assign mem.mem_we         = 1'b0;
  assign mem.mem_write_data = 32'h0;
`endif

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    base_d      = base_q;
    target_d    = target_q;
    found_d     = found_q;
    win_d       = win_q;
    min_nonce_d = min_nonce_q;
    min_h0_d    = min_h0_q;
    addr_d      = addr_q;
`ifdef SCAN_WRITEBACK_EN
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    k_d         = k_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RADDR;
          base_d      = result_addr;
          target_d    = target;
          n_d         = 5'd0;
          found_d     = 1'b0;
          win_d       = 5'd0;
          min_nonce_d = 5'd0;
          min_h0_d    = 32'hFFFF_FFFF;
        end
      end
      S_RADDR: begin
        addr_d  = base_q + {8'b0, n_q, 3'b0};
        state_d = S_RWAIT;
      end
      S_RWAIT: state_d = S_RCAP;
      S_RCAP: begin
        // Both tests look at pre-edge registers, so a single H0 can win and set the minimum.
        if (!found_q && (h0 < target_q)) begin
          found_d = 1'b1;
          win_d   = n_q;
        end
        if (h0 < min_h0_q) begin
          min_h0_d    = h0;
          min_nonce_d = n_q;
        end
        if (n_q == LAST_N) begin
`ifdef SCAN_WRITEBACK_EN
          state_d = S_WB;
          k_d     = 2'd0;
          we_d    = 1'b1;
          addr_d  = base_q + WB_OFFS;
          wdata_d = {31'b0, found_d};
`else
          state_d = S_IDLE;
`endif
        end else begin
          n_d     = n_q + 5'd1;
          state_d = S_RADDR;
        end
      end
`ifdef SCAN_WRITEBACK_EN
      S_WB: begin
        // Word k is on the bus during this cycle; set up word k+1 or release the bus.
        if (k_q == 2'd3) begin
          state_d = S_IDLE;
        end else begin
          k_d     = k_next;
          we_d    = 1'b1;
          addr_d  = base_q + WB_OFFS + {14'b0, k_next};
          wdata_d = wb_word(k_next, found_q, win_q, min_nonce_q, min_h0_q);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      n_q         <= 5'd0;
      base_q      <= 16'h0;
      target_q    <= 32'h0;
      found_q     <= 1'b0;
      win_q       <= 5'd0;
      min_nonce_q <= 5'd0;
      min_h0_q    <= 32'hFFFF_FFFF;
      addr_q      <= 16'h0;
`ifdef SCAN_WRITEBACK_EN
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      k_q         <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      base_q      <= base_d;
      target_q    <= target_d;
      found_q     <= found_d;
      win_q       <= win_d;
      min_nonce_q <= min_nonce_d;
      min_h0_q    <= min_h0_d;
      addr_q      <= addr_d;
`ifdef SCAN_WRITEBACK_EN
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
`endif
    end
  end

endmodule
